// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter.
// Captures a WIDTH-bit word on a load request and shifts it out one bit per
// BIT_CYCLES clock cycles. A one-cycle so_strobe marks each bit as valid, and
// a one-cycle done pulse follows the last bit.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   load       start request (one-cycle pulse expected); ignored while busy
//   pi         parallel word, sampled only when load is accepted
//   so         serial data out (0 when no frame is shifting)
//   so_strobe  one-cycle pulse in the last cycle of each bit period
//   busy       high while a frame is in progress (SHIFT or DONE)
//   done       one-cycle pulse after the last bit of a frame
module piso_tx #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned BIT_CYCLES = 4,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] pi,
  output logic             so,
  output logic             so_strobe,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW  = $clog2(BIT_CYCLES);
  localparam int unsigned BitnW = $clog2(WIDTH) + 1;

  localparam logic [CntW-1:0]  CntLast  = CntW'(BIT_CYCLES - 1);
  localparam logic [BitnW-1:0] BitnLast = BitnW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CntW-1:0]    cnt_q,   cnt_d;
  logic [BitnW-1:0]   bitn_q,  bitn_d;

  logic head_bit;
  logic bit_end;

  // The bit on the line is always at the head of the shift register; the
  // register moves toward the head after each strobe.
  assign head_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign bit_end  = (state_q == StShift) && (cnt_q == CntLast);

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    bitn_d  = bitn_q;

    unique case (state_q)
      StIdle: begin
        if (load) begin
          shreg_d = pi;
          cnt_d   = '0;
          bitn_d  = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          bitn_d  = bitn_q + BitnW'(1);
          shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
          if (bitn_q == BitnLast) begin
            state_d = StDone;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
      bitn_q  <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      bitn_q  <= bitn_d;
    end
  end

  // Outputs decode from state only, so load/pi never reach them combinationally.
  always_comb begin
    so        = (state_q == StShift) && head_bit;
    so_strobe = bit_end;
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
  end

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx. Three instances share load/pi:
//   0: WIDTH=4 BIT_CYCLES=4 MSB first
//   1: WIDTH=4 BIT_CYCLES=4 LSB first
//   2: WIDTH=1 BIT_CYCLES=2 MSB first
// A frame model records when each instance accepts a load and pushes the
// expected strobe events into a per-instance queue; a monitor on the falling
// edge pops and compares them and checks so/busy/done against the frame window.
module tb_piso_tx;

  typedef struct {
    int   e;
    logic b;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [3:0] pi = 4'h0;

  logic [2:0] so_w, strb_w, busy_w, done_w;

  int cw  [3] = '{4, 4, 1};
  int cbc [3] = '{4, 4, 2};
  bit cmsb[3] = '{1'b1, 1'b0, 1'b1};

  int total  = 0;
  int bad    = 0;
  int edge_n = 0;

  bit         active[3];
  int         e_st  [3];
  logic [3:0] word  [3];
  ev_t        sq    [3][$];

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(4), .BIT_CYCLES(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .load(load), .pi(pi),
    .so(so_w[0]), .so_strobe(strb_w[0]), .busy(busy_w[0]), .done(done_w[0])
  );

  piso_tx #(.WIDTH(4), .BIT_CYCLES(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .load(load), .pi(pi),
    .so(so_w[1]), .so_strobe(strb_w[1]), .busy(busy_w[1]), .done(done_w[1])
  );

  piso_tx #(.WIDTH(1), .BIT_CYCLES(2), .MSB_FIRST(1'b1)) u_w1 (
    .clk(clk), .rst(rst), .load(load), .pi(pi[0:0]),
    .so(so_w[2]), .so_strobe(strb_w[2]), .busy(busy_w[2]), .done(done_w[2])
  );

  task automatic chk1(input string name, input int idx, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d edge=%0d got=%b want=%b", name, idx, edge_n, act, exp);
    end
  endtask

  task automatic chkn(input string name, input int idx, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s dut%0d got=%0d want=%0d", name, idx, act, exp);
    end
  endtask

  task automatic abort_model();
    for (int i = 0; i < 3; i++) begin
      active[i] = 1'b0;
      sq[i].delete();
    end
  endtask

  task automatic check_all_zero(input string name);
    for (int i = 0; i < 3; i++) begin
      chk1({name, "_so"},   i, so_w[i],   1'b0);
      chk1({name, "_strb"}, i, strb_w[i], 1'b0);
      chk1({name, "_busy"}, i, busy_w[i], 1'b0);
      chk1({name, "_done"}, i, done_w[i], 1'b0);
    end
  endtask

  // Frame model: a load seen at edge e is accepted if the instance is idle in
  // the cycle before e; strobe k (1..W) then falls in the cycle after edge
  // e+k*BC-1 and done in the cycle after edge e+W*BC.
  initial begin
    forever begin
      @(posedge clk);
      edge_n++;
      if (!rst && load) begin
        for (int i = 0; i < 3; i++) begin
          if (!active[i] || edge_n >= e_st[i] + cw[i] * cbc[i] + 2) begin
            ev_t ev;
            active[i] = 1'b1;
            e_st[i]   = edge_n;
            word[i]   = pi;
            for (int k = 1; k <= cw[i]; k++) begin
              ev.e = edge_n + k * cbc[i] - 1;
              ev.b = cmsb[i] ? pi[cw[i] - k] : pi[k - 1];
              sq[i].push_back(ev);
            end
          end
        end
      end
    end
  end

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        int   p;
        int   span;
        logic exp_busy, exp_done, exp_so, exp_strb;
        p        = edge_n;
        span     = cw[i] * cbc[i];
        exp_busy = active[i] && p >= e_st[i] && p <= e_st[i] + span;
        exp_done = active[i] && p == e_st[i] + span;
        exp_so   = 1'b0;
        if (active[i] && p >= e_st[i] && p < e_st[i] + span) begin
          int j;
          j      = (p - e_st[i]) / cbc[i];
          exp_so = cmsb[i] ? word[i][cw[i] - 1 - j] : word[i][j];
        end
        exp_strb = (sq[i].size() > 0) && (sq[i][0].e == p);
        chk1("busy", i, busy_w[i], exp_busy);
        chk1("done", i, done_w[i], exp_done);
        chk1("so",   i, so_w[i],   exp_so);
        chk1("strobe", i, strb_w[i], exp_strb);
        if (exp_strb) begin
          ev_t ev;
          ev = sq[i].pop_front();
          chk1("strobe_bit", i, so_w[i], ev.b);
        end
      end
    end
  end

  task automatic pulse(input logic [3:0] v);
    @(negedge clk);
    pi   = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic idle(input int n);
    load = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Called just after a falling edge: rst rises mid-cycle.
  task automatic reset_mid(input int hold);
    #2;
    rst = 1'b1;
    abort_model();
    #1;
    check_all_zero("rst_async");
    repeat (hold) @(negedge clk);
    check_all_zero("rst_held");
    #2;
    rst = 1'b0;
  endtask

  initial begin
    abort_model();
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;

    // Single frame, both bit orders
    pulse(4'b1011);
    idle(20);

    // Load while busy is ignored; pi churns mid-frame
    pulse(4'b0110);
    repeat (4) @(negedge clk);
    pi   = 4'b1111;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (5) begin
      @(negedge clk);
      pi = 4'($urandom);
    end
    idle(15);

    // Reset mid-frame, then a fresh frame
    pulse(4'b1010);
    repeat (7) @(negedge clk);
    reset_mid(2);
    pulse(4'b0101);
    idle(20);

    // Load held high: back-to-back frames
    @(negedge clk);
    pi   = 4'b1001;
    load = 1'b1;
    repeat (40) @(negedge clk);
    load = 1'b0;
    idle(20);

    // Random traffic with occasional resets
    repeat (400) begin
      @(negedge clk);
      load = ($urandom_range(0, 5) == 0);
      pi   = 4'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        reset_mid(1 + $urandom_range(0, 2));
      end
    end
    idle(40);

    for (int i = 0; i < 3; i++) begin
      chkn("strobes_left", i, sq[i].size(), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
- Parallel-in serial-out transmitter: the sending end of the bit-serial link whose receiver is the sipo shift register.
- On a load request it captures a WIDTH-bit word and shifts it out one bit per bit period on so.
- A one-cycle so_strobe marks each bit as valid, playing the role the debounced button pulse plays for the receiver.
- Sits between switch/register sources and a sipo-style receiver, with busy and done reported to LEDs or control logic.

Parameters:
- WIDTH, 4, number of bits per frame (>=1).
- BIT_CYCLES, 4, clk cycles per bit period (>=2); 100000 in hardware, small values in simulation.
- MSB_FIRST, 1, 1 = transmit pi[WIDTH-1] first; 0 = transmit pi[0] first.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- load  input  1  start request; a one-cycle pulse is expected (e.g. debounced button).
- pi  input  WIDTH  parallel word, sampled only when load is accepted.
- so  output  1  serial data out.
- so_strobe  output  1  one-cycle pulse; so is valid and stable during it.
- busy  output  1  high while a frame is in progress (SHIFT or DONE).
- done  output  1  one-cycle pulse after the last bit of a frame.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE; shift register, bit counter and cycle counter cleared.
  - so=0, so_strobe=0, busy=0, done=0.
- States: IDLE, SHIFT, DONE. All outputs decode from registers; there is no combinational path from any input to any output.
- IDLE:
  - busy=0, so=0.
  - If load=1 at a rising edge: pi is captured into the shift register, cnt=0, bitn=0, next state SHIFT.
  - If load=0: remain in IDLE.
- SHIFT:
  - busy=1; so = current head bit (MSB or LSB per MSB_FIRST).
  - cnt increments every cycle from 0 to BIT_CYCLES-1.
  - so_strobe = (state==SHIFT && cnt==BIT_CYCLES-1).
  - At the edge ending a strobe cycle: shift register advances one bit, cnt=0, bitn increments.
  - If bitn==WIDTH-1 at that edge, next state DONE instead.
  - Each bit is held on so for exactly BIT_CYCLES cycles.
- DONE:
  - Lasts one cycle; busy=1, done=1, so=0, so_strobe=0.
  - Unconditionally returns to IDLE.
- Latency: load sampled at edge 0, so:
  - SHIFT begins in cycle 1.
  - Strobes occur in cycles k*BIT_CYCLES, for k=1..WIDTH.
  - done occurs in cycle WIDTH*BIT_CYCLES+1.
  - IDLE is reached in cycle WIDTH*BIT_CYCLES+2.
- Boundary conditions:
  - load while busy (SHIFT or DONE): ignored; the frame in progress and the captured word are unaffected.
  - load held high: re-sampled in the first IDLE cycle, giving back-to-back frames separated by one IDLE cycle.
  - pi changing mid-frame: no effect on the frame.
  - WIDTH=1: exactly one strobe, then DONE.
  - Reset mid-frame: frame aborted; no further strobes and no done pulse; the next load starts a fresh frame.
  - cnt width = clog2(BIT_CYCLES); cnt never exceeds BIT_CYCLES-1.
  - bitn width = clog2(WIDTH)+1.

Test Plan (WIDTH=4, BIT_CYCLES=4 unless stated):
1. Reset: assert rst mid-cycle with outputs active -> so, so_strobe, busy, done all 0 immediately, before the next clk edge; remain 0 while rst is held.
2. pi=4'b1011, load pulsed at edge 0 (MSB_FIRST=1):
   - so = 1,0,1,1, each held 4 cycles.
   - so_strobe high in cycles 4, 8, 12, 16 only.
   - done high in cycle 17 only; busy high in cycles 1-17; IDLE with busy=0 in cycle 18.
3. MSB_FIRST=0, pi=4'b1011 -> so = 1,1,0,1 with the same strobe and done timing as scenario 2.
4. pi=4'b0110 loaded, then load pulsed in cycle 6 with pi=4'b1111 -> second load ignored; so = 0,1,1,0; exactly 4 strobes; one done pulse in cycle 17.
5. Async rst asserted in cycle 9 of a frame (pi=4'b1010), released in cycle 11, then load with pi=4'b0101:
   - No strobes and no done occur from cycle 9 until the new frame.
   - New frame is so = 0,1,0,1, with strobes at load+4k cycles.
6. load held high for 40 cycles, pi=4'b1001:
   - First frame strobes in cycles 4-16 (every 4 cycles), done in cycle 17, IDLE in cycle 18.
   - Second frame starts SHIFT in cycle 19, strobes in cycles 22, 26, 30, 34, done in cycle 35.
   - Bench checks so = 1,0,0,1 in both frames.
